// File: rtl/eth_rx_frame_gate.sv
// eth_rx_frame_gate: store-and-forward receive gate; forwards only complete good frames,
// silently dropping errored or oversize frames, and never backpressures the MAC.
module eth_rx_frame_gate #(
    parameter int MTU = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] s_tdata,
    input  logic [3:0]  s_tuser,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [63:0] m_tdata,
    output logic [3:0]  m_tuser,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] err_drop_cnt,
    output logic [15:0] ovf_drop_cnt
);
    typedef enum logic {ACCEPT, DROP} state_t;
    localparam logic [MTU-1:0] ONE = 1;

    state_t         r_state, w_next;
    logic [67:0]    r_mem [2**MTU];
    logic [MTU-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, w_wr_nxt;
    logic [15:0]    r_err_cnt, r_ovf_cnt;
    logic [67:0]    r_pf, r_out;
    logic           r_pf_vld, r_out_vld;
    logic           w_full, w_avail, w_we, w_commit, w_err_inc, w_ovf_inc, w_out_ld, w_pf_ld;

    assign w_wr_nxt = r_wr_ptr + ONE;
    // full uses the registered read pointer, so a same-cycle read never frees a slot
    assign w_full   = (w_wr_nxt == r_rd_ptr);
    assign w_avail  = (r_rd_ptr != r_commit_ptr);
    assign w_out_ld = !r_out_vld || m_tready;
    assign w_pf_ld  = w_avail && (!r_pf_vld || w_out_ld);

    always_comb begin
        w_next    = r_state;
        w_we      = 1'b0;
        w_commit  = 1'b0;
        w_err_inc = 1'b0;
        w_ovf_inc = 1'b0;
        if (s_tvalid) begin
            if (r_state == DROP) begin
                w_next = s_tlast ? ACCEPT : DROP;
            end else if (w_full) begin
                w_ovf_inc = 1'b1;
                w_next    = s_tlast ? ACCEPT : DROP;
            end else begin
                w_we      = 1'b1;
                w_commit  = s_tlast && !s_tuser[3];
                w_err_inc = s_tlast && s_tuser[3];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ACCEPT;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_err_cnt    <= '0;
            r_ovf_cnt    <= '0;
            r_pf_vld     <= 1'b0;
            r_out_vld    <= 1'b0;
            r_out        <= '0;
        end else begin
            r_state <= w_next;
            if (w_err_inc || w_ovf_inc)
                r_wr_ptr <= r_commit_ptr;
            else if (w_we)
                r_wr_ptr <= w_wr_nxt;
            if (w_commit)
                r_commit_ptr <= w_wr_nxt;
            if (w_err_inc && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
            if (w_ovf_inc && r_ovf_cnt != 16'hFFFF)
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            if (w_pf_ld)
                r_rd_ptr <= r_rd_ptr + ONE;
            r_pf_vld <= w_pf_ld || (r_pf_vld && !w_out_ld);
            if (w_out_ld) begin
                r_out_vld <= r_pf_vld;
                if (r_pf_vld)
                    r_out <= r_pf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wr_ptr] <= {s_tlast, s_tuser[2:0], s_tdata};
        if (w_pf_ld)
            r_pf <= r_mem[r_rd_ptr];
    end

    assign s_tready     = 1'b1;
    assign m_tdata      = r_out[63:0];
    assign m_tuser      = {1'b0, r_out[66:64]};
    assign m_tlast      = r_out[67];
    assign m_tvalid     = r_out_vld;
    assign err_drop_cnt = r_err_cnt;
    assign ovf_drop_cnt = r_ovf_cnt;
endmodule

// File: tb/tb_eth_rx_frame_gate.sv
// tb_eth_rx_frame_gate: directed bench with an expected-beat queue and output monitor.
module tb_eth_rx_frame_gate;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [3:0]  s_tuser = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [3:0]  m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] err_drop_cnt, ovf_drop_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          hold_pend = 1'b0;
    logic [68:0] hold_val;
    logic [68:0] exp_q [$];

    eth_rx_frame_gate #(.MTU(4)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .err_drop_cnt(err_drop_cnt), .ovf_drop_cnt(ovf_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // outputs only change on posedge; sample them mid-cycle
    always @(negedge clk) begin
        logic [68:0] e;
        if (mon_en && !reset) begin
            if (hold_pend)
                chk("hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, hold_val});
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", m_tvalid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_tlast, m_tuser, m_tdata}, e);
                end
            end
            hold_pend = m_tvalid && !m_tready;
            hold_val  = {m_tlast, m_tuser, m_tdata};
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic [3:0] u, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] ulast, input bit keep);
        logic [63:0] d;
        logic [3:0]  u;
        logic        l;
        for (int i = 0; i < n; i++) begin
            l = (i == n - 1);
            u = l ? ulast : {1'b0, 3'(i)};
            d = {base, 32'(i)};
            if (keep)
                exp_q.push_back({l, 1'b0, u[2:0], d});
            beat(d, u, l);
        end
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        repeat (4) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tuser", m_tuser, 4'h0);
        chk("rst_tdata", m_tdata, 64'h0);
        chk("rst_err", err_drop_cnt, 16'h0);
        chk("rst_ovf", ovf_drop_cnt, 16'h0);
        reset = 1'b0;
        tick();
        chk("tready", s_tready, 1'b1);
        mon_en = 1'b1;

        // good frame and output latency
        send_frame(10, 32'hA11C_E000, 4'h3, 1'b1);
        chk("lat_at_T", m_tvalid, 1'b0);
        @(negedge clk);
        chk("lat_before_T1", m_tvalid, 1'b0);
        @(negedge clk);
        chk("lat_after_T1", m_tvalid, 1'b0);
        @(negedge clk);
        chk("lat_after_T2", m_tvalid, 1'b1);
        tick();
        drain("drain_good");
        chk("good_err", err_drop_cnt, 16'h0);
        chk("good_ovf", ovf_drop_cnt, 16'h0);

        // error frame sandwiched between good frames
        send_frame(3, 32'h0000_00AA, 4'h1, 1'b1);
        send_frame(5, 32'h0000_00BB, 4'h9, 1'b0);
        send_frame(4, 32'h0000_00CC, 4'h0, 1'b1);
        drain("drain_err");
        chk("err_cnt1", err_drop_cnt, 16'h1);
        chk("err_ovf0", ovf_drop_cnt, 16'h0);

        // oversize frame with an errored tail: counted once, as overflow
        m_tready = 1'b0;
        send_frame(20, 32'h0000_0050, 4'h8, 1'b0);
        repeat (4) tick();
        chk("ovf_no_out", m_tvalid, 1'b0);
        chk("ovf_cnt1", ovf_drop_cnt, 16'h1);
        chk("ovf_err_kept", err_drop_cnt, 16'h1);
        m_tready = 1'b1;
        send_frame(4, 32'h0000_0060, 4'h2, 1'b1);
        drain("drain_after_ovf");

        // exactly 15 beats fits an empty buffer
        m_tready = 1'b0;
        send_frame(15, 32'h0000_0070, 4'h7, 1'b1);
        repeat (6) tick();
        chk("fit15_valid", m_tvalid, 1'b1);
        chk("fit15_ovf", ovf_drop_cnt, 16'h1);
        m_tready = 1'b1;
        drain("drain_fit15");

        // backpressure
        fork
            begin
                send_frame(4, 32'h0000_0081, 4'h4, 1'b1);
                send_frame(3, 32'h0000_0082, 4'h5, 1'b1);
                send_frame(5, 32'h0000_0083, 4'h6, 1'b1);
            end
            begin
                repeat (80) begin
                    m_tready = 1'($urandom_range(0, 1));
                    tick();
                end
                m_tready = 1'b1;
            end
        join
        drain("drain_bp");
        chk("bp_ovf", ovf_drop_cnt, 16'h1);

        // reset while output streams and a second frame is mid-flight
        send_frame(6, 32'h0000_00A0, 4'h1, 1'b1);
        beat({32'h0000_00B0, 32'h0}, 4'h0, 1'b0);
        beat({32'h0000_00B0, 32'h1}, 4'h0, 1'b0);
        chk("pre_rst_valid", m_tvalid, 1'b1);
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", m_tvalid, 1'b0);
        chk("mid_rst_err", err_drop_cnt, 16'h0);
        chk("mid_rst_ovf", ovf_drop_cnt, 16'h0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        tick();
        send_frame(5, 32'h0000_00C0, 4'h5, 1'b1);
        drain("drain_post_rst");

        // error counter saturation
        for (int k = 0; k < 65534; k++)
            beat(64'(k), 4'h8, 1'b1);
        chk("sat_fffe", err_drop_cnt, 16'hFFFE);
        repeat (3) beat(64'hDEAD, 4'h8, 1'b1);
        chk("sat_ffff", err_drop_cnt, 16'hFFFF);
        chk("sat_ovf0", ovf_drop_cnt, 16'h0);
        drain("drain_sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
